// File: rtl/vga_fb_pkg.sv
// Shared types and default geometry for the frame-buffer arbiter and its users.
// Holds the image/pixel/offset widths, the {bank, offset} address struct, the
// read-pipeline tag and the grant encoding.
package vga_fb_pkg;

    localparam int unsigned IMG_W       = 320;
    localparam int unsigned IMG_H       = 240;
    localparam int unsigned SCALE_SHIFT = 1;
    localparam int unsigned PIX_W       = 4;
    localparam int unsigned OFF_W       = 17;
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned ADDR_W      = OFF_W + 1;

    typedef logic [PIX_W-1:0]   pix_t;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [OFF_W-1:0]   offset_t;

    typedef struct packed {
        logic    bank;
        offset_t offset;
    } fb_addr_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_CONV
    } rd_tag_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DISP,
        GNT_WR,
        GNT_RD
    } grant_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter, its requesters and the BRAM.
// slave  : arbiter view (requests and mem_rdata in; grants, responses, mem_* out).
// master : requester/BRAM view (the mirror image).
interface vga_fb_arbiter_if;
    import vga_fb_pkg::*;

    logic     display_enable;
    logic     disp_req;
    coord_t   disp_x;
    coord_t   disp_y;
    pix_t     disp_pixel;
    logic     disp_valid;

    logic     conv_wr_req;
    fb_addr_t conv_wr_addr;
    pix_t     conv_wr_data;
    logic     conv_wr_ack;

    logic     conv_rd_req;
    fb_addr_t conv_rd_addr;
    logic     conv_rd_ack;
    pix_t     conv_rd_data;
    logic     conv_rd_valid;

    logic     swap_req;
    logic     swap_done;
    logic     front_sel;

    logic     mem_en;
    logic     mem_we;
    fb_addr_t mem_addr;
    pix_t     mem_wdata;
    pix_t     mem_rdata;

    modport slave (
        input  display_enable, disp_req, disp_x, disp_y,
        input  conv_wr_req, conv_wr_addr, conv_wr_data,
        input  conv_rd_req, conv_rd_addr,
        input  swap_req, mem_rdata,
        output disp_pixel, disp_valid,
        output conv_wr_ack, conv_rd_ack, conv_rd_data, conv_rd_valid,
        output swap_done, front_sel,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output display_enable, disp_req, disp_x, disp_y,
        output conv_wr_req, conv_wr_addr, conv_wr_data,
        output conv_rd_req, conv_rd_addr,
        output swap_req, mem_rdata,
        input  disp_pixel, disp_valid,
        input  conv_wr_ack, conv_rd_ack, conv_rd_data, conv_rd_valid,
        input  swap_done, front_sel,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/fb_addr_map.sv
// Combinational screen (x, y) to stored-image offset mapping.
// x, y       : screen coordinates
// in_image_c : downscaled coordinate lies inside the stored image
// offset_c   : row-major offset (y >> S) * IMG_W + (x >> S); meaningless when !in_image_c
module fb_addr_map #(
    parameter int unsigned IMG_W       = vga_fb_pkg::IMG_W,
    parameter int unsigned IMG_H       = vga_fb_pkg::IMG_H,
    parameter int unsigned SCALE_SHIFT = vga_fb_pkg::SCALE_SHIFT
) (
    input  vga_fb_pkg::coord_t  x,
    input  vga_fb_pkg::coord_t  y,
    output logic                in_image_c,
    output vga_fb_pkg::offset_t offset_c
);

    localparam int unsigned OFF_W = $bits(vga_fb_pkg::offset_t);

    vga_fb_pkg::coord_t x_img;
    vga_fb_pkg::coord_t y_img;

    assign x_img = x >> SCALE_SHIFT;
    assign y_img = y >> SCALE_SHIFT;

    assign in_image_c = (32'(x_img) < IMG_W) && (32'(y_img) < IMG_H);
    // IMG_W is a constant, so the multiply folds to shift-and-add
    assign offset_c   = OFF_W'(y_img) * OFF_W'(IMG_W) + OFF_W'(x_img);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer BRAM arbiter: display fetch > conv write > conv read,
// plus front/back bank selection with swaps applied at frame start.
// clk, reset : 100 MHz clock, asynchronous active-low reset
// bus        : display fetch, conv read/write ports, swap control and BRAM port
module vga_fb_arbiter
    import vga_fb_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    vga_fb_arbiter_if.slave bus
);

    logic     in_image_c;
    offset_t  disp_off_c;
    logic     disp_hit_c;
    logic     frame_start_c;
    logic     swap_now_c;
    fb_addr_t disp_addr_c;
    grant_t   grant_c;

    logic     swap_pending;
    rd_tag_t  tag1;
    rd_tag_t  tag2;
    logic     miss1;
    logic     miss2;

    fb_addr_map #(
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .SCALE_SHIFT (SCALE_SHIFT)
    ) u_addr_map (
        .x          (bus.disp_x),
        .y          (bus.disp_y),
        .in_image_c (in_image_c),
        .offset_c   (disp_off_c)
    );

    assign disp_hit_c    = bus.disp_req && bus.display_enable && in_image_c;
    assign frame_start_c = bus.disp_req && (bus.disp_x == '0) && (bus.disp_y == '0);
    // A swap_req arriving on the frame-start cycle itself applies immediately
    assign swap_now_c    = frame_start_c && (swap_pending || bus.swap_req);
    assign disp_addr_c   = '{bank: bus.front_sel ^ swap_now_c, offset: disp_off_c};

    // Fixed-priority grant
    always_comb begin
        grant_c = GNT_NONE;
        if (disp_hit_c) begin
            grant_c = GNT_DISP;
        end else if (bus.conv_wr_req) begin
            grant_c = GNT_WR;
        end else if (bus.conv_rd_req) begin
            grant_c = GNT_RD;
        end
    end

    assign bus.conv_wr_ack  = (grant_c == GNT_WR);
    assign bus.conv_rd_ack  = (grant_c == GNT_RD);
    // Read data arrives straight from the BRAM; zeroed outside its valid pulse
    assign bus.conv_rd_data = bus.conv_rd_valid ? bus.mem_rdata : '0;

    // Issue stage: register the granted access onto the BRAM port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            tag1          <= TAG_NONE;
            miss1         <= 1'b0;
        end else begin
            bus.mem_en <= (grant_c != GNT_NONE);
            bus.mem_we <= (grant_c == GNT_WR);
            tag1       <= TAG_NONE;
            miss1      <= bus.disp_req && !disp_hit_c;
            case (grant_c)
                GNT_DISP: begin
                    bus.mem_addr <= disp_addr_c;
                    tag1         <= TAG_DISP;
                end
                GNT_WR: begin
                    bus.mem_addr  <= bus.conv_wr_addr;
                    bus.mem_wdata <= bus.conv_wr_data;
                end
                GNT_RD: begin
                    bus.mem_addr <= bus.conv_rd_addr;
                    tag1         <= TAG_CONV;
                end
                default: ;
            endcase
        end
    end

    // Return stage: route mem_rdata by tag; display misses still emit a black pixel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag2              <= TAG_NONE;
            miss2             <= 1'b0;
            bus.conv_rd_valid <= 1'b0;
            bus.disp_valid    <= 1'b0;
            bus.disp_pixel    <= '0;
        end else begin
            tag2              <= tag1;
            miss2             <= miss1;
            bus.conv_rd_valid <= (tag1 == TAG_CONV);
            bus.disp_valid    <= (tag2 == TAG_DISP) || miss2;
            if (tag2 == TAG_DISP) begin
                bus.disp_pixel <= bus.mem_rdata;
            end else if (miss2) begin
                bus.disp_pixel <= '0;
            end
        end
    end

    // Bank swap: repeated requests collapse into one pending toggle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.front_sel <= 1'b0;
            bus.swap_done <= 1'b0;
            swap_pending  <= 1'b0;
        end else begin
            bus.swap_done <= swap_now_c;
            if (swap_now_c) begin
                bus.front_sel <= ~bus.front_sel;
                swap_pending  <= 1'b0;
            end else if (bus.swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

endmodule
